// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared widths, start position and scan state encoding for the snake body store
package snake_pkg;
   localparam int DEF_COORD_BIT        = 7;
   localparam int DEF_SNAKE_LENGTH_BIT = 4;
   localparam int DEF_INIT_LENGTH      = 3;
   localparam int DEF_START_X          = 20;
   localparam int DEF_START_Y          = 15;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

   function automatic int depth_of(input int length_bit);
      return 2 ** length_bit;
   endfunction

   function automatic int max_len_of(input int length_bit);
      return depth_of(length_bit) - 1;
   endfunction
endpackage

// File: rtl/snake_body_scan.sv
// rtl/snake_body_scan.sv - sequential self-collision scan: compares segment j against the head, one per cycle
module snake_body_scan import snake_pkg::*; #(
   parameter int COORD_BIT        = DEF_COORD_BIT,
   parameter int SNAKE_LENGTH_BIT = DEF_SNAKE_LENGTH_BIT
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        restart,
   input  logic                        start,
   input  logic [SNAKE_LENGTH_BIT-1:0] length,
   input  logic [COORD_BIT-1:0]        head_x,
   input  logic [COORD_BIT-1:0]        head_y,
   input  logic [COORD_BIT-1:0]        seg_x,
   input  logic [COORD_BIT-1:0]        seg_y,
   output logic [SNAKE_LENGTH_BIT-1:0] seg_index,
   output logic                        busy,
   output logic                        self_hit,
   output logic                        scan_done
);
   localparam logic [SNAKE_LENGTH_BIT-1:0] ONE = SNAKE_LENGTH_BIT'(1);

   scan_state_t state;
   logic        hit;
   logic        match;

   assign match     = (seg_x == head_x) && (seg_y == head_y);
   assign busy      = (state != IDLE);

   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         seg_index <= ONE;
         hit       <= 1'b0;
         self_hit  <= 1'b0;
         scan_done <= 1'b0;
      end else if (restart) begin
         state     <= IDLE;
         seg_index <= ONE;
         hit       <= 1'b0;
         self_hit  <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         self_hit  <= 1'b0;
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  seg_index <= ONE;
                  hit       <= 1'b0;
               end
            end
            SCAN: begin
               hit <= hit | match;
               // Last body segment: fold its compare straight into the registered pulse.
               if (seg_index == length - ONE) begin
                  state     <= DONE;
                  scan_done <= 1'b1;
                  self_hit  <= hit | match;
               end else begin
                  seg_index <= seg_index + ONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - circular snake segment store with read port and collision scan; SNAKE_TAIL_OUT_EN adds tail erase outputs
module snake_body_store import snake_pkg::*; #(
   parameter int COORD_BIT        = DEF_COORD_BIT,
   parameter int SNAKE_LENGTH_BIT = DEF_SNAKE_LENGTH_BIT,
   parameter int INIT_LENGTH      = DEF_INIT_LENGTH,
   parameter int START_X          = DEF_START_X,
   parameter int START_Y          = DEF_START_Y
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        restart,
   input  logic                        step,
   input  logic                        grow,
   input  logic [COORD_BIT-1:0]        head_x_in,
   input  logic [COORD_BIT-1:0]        head_y_in,
   input  logic [SNAKE_LENGTH_BIT-1:0] rd_index,
   output logic [COORD_BIT-1:0]        rd_x,
   output logic [COORD_BIT-1:0]        rd_y,
   output logic                        rd_valid,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        full,
   output logic                        busy,
   output logic                        self_hit,
   output logic                        scan_done,
`ifdef SNAKE_TAIL_OUT_EN
   output logic [COORD_BIT-1:0]        tail_x,
   output logic [COORD_BIT-1:0]        tail_y,
   output logic                        tail_valid,
`endif
   output logic                        overrun
);
   localparam int L     = SNAKE_LENGTH_BIT;
   localparam int DEPTH = depth_of(L);
   localparam logic [L-1:0] ONE      = L'(1);
   localparam logic [L-1:0] MAX_LEN  = L'(max_len_of(L));
   localparam logic [L-1:0] INIT_LEN = L'(INIT_LENGTH);
   localparam logic [L-1:0] INIT_PTR = L'(INIT_LENGTH - 1);

   logic [COORD_BIT-1:0] mem_x  [DEPTH];
   logic [COORD_BIT-1:0] mem_y  [DEPTH];
   logic [COORD_BIT-1:0] next_x [DEPTH];
   logic [COORD_BIT-1:0] next_y [DEPTH];
   logic [COORD_BIT-1:0] init_x [DEPTH];
   logic [COORD_BIT-1:0] init_y [DEPTH];
   logic [L-1:0]         head_ptr, next_ptr, next_len, scan_index, rd_addr;
   logic                 accept, grows, rd_ok;

   assign full   = (snake_length == MAX_LEN);
   assign accept = step && !busy && !restart;
   assign grows  = grow && !full;

   // Initial snake lies horizontally with the head at the start position, tail extending to -x.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         init_x[k] = '0;
         init_y[k] = '0;
         if (k < INIT_LENGTH) begin
            init_x[k] = COORD_BIT'(START_X - (INIT_LENGTH - 1 - k));
            init_y[k] = COORD_BIT'(START_Y);
         end
      end
   end

   always_comb begin
      next_x   = mem_x;
      next_y   = mem_y;
      next_ptr = head_ptr;
      next_len = snake_length;
      if (restart) begin
         next_x   = init_x;
         next_y   = init_y;
         next_ptr = INIT_PTR;
         next_len = INIT_LEN;
      end else if (accept) begin
         next_ptr         = head_ptr + ONE;
         next_x[next_ptr] = head_x_in;
         next_y[next_ptr] = head_y_in;
         if (grows) next_len = snake_length + ONE;
      end
   end

   // Read port looks at post-update state so a same-cycle step is visible immediately.
   assign rd_addr = next_ptr - rd_index;
   assign rd_ok   = (rd_index < next_len);

   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         mem_x        <= init_x;
         mem_y        <= init_y;
         head_ptr     <= INIT_PTR;
         snake_length <= INIT_LEN;
         rd_x         <= '0;
         rd_y         <= '0;
         rd_valid     <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         mem_x        <= next_x;
         mem_y        <= next_y;
         head_ptr     <= next_ptr;
         snake_length <= next_len;
         rd_valid     <= rd_ok;
         rd_x         <= rd_ok ? next_x[rd_addr] : '0;
         rd_y         <= rd_ok ? next_y[rd_addr] : '0;
         if (restart)          overrun <= 1'b0;
         else if (step && busy) overrun <= 1'b1;
      end
   end

`ifdef SNAKE_TAIL_OUT_EN
   logic [L-1:0] tail_addr;
   assign tail_addr = head_ptr - (snake_length - ONE);

   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         tail_x     <= '0;
         tail_y     <= '0;
         tail_valid <= 1'b0;
      end else if (restart) begin
         tail_x     <= '0;
         tail_y     <= '0;
         tail_valid <= 1'b0;
      end else begin
         tail_valid <= accept && !grows;
         if (accept && !grows) begin
            tail_x <= mem_x[tail_addr];
            tail_y <= mem_y[tail_addr];
         end
      end
   end
`endif

   snake_body_scan #(
      .COORD_BIT        (COORD_BIT),
      .SNAKE_LENGTH_BIT (SNAKE_LENGTH_BIT)
   ) u_scan (
      .clock_25  (clock_25),
      .reset     (reset),
      .restart   (restart),
      .start     (accept),
      .length    (snake_length),
      .head_x    (mem_x[head_ptr]),
      .head_y    (mem_y[head_ptr]),
      .seg_x     (mem_x[head_ptr - scan_index]),
      .seg_y     (mem_y[head_ptr - scan_index]),
      .seg_index (scan_index),
      .busy      (busy),
      .self_hit  (self_hit),
      .scan_done (scan_done)
   );
endmodule
